// File: rtl/lapido_hazard_ctrl_pkg.sv
// lapido_hazard_ctrl_pkg
//   Shared constants and types for the lapido hazard controller:
//   forward-select encoding, FSM state encoding and a helper that sizes
//   the load-stall countdown register.
package lapido_hazard_ctrl_pkg;

    // Forward select value meaning "take operand from the register file".
    localparam int FWD_SEL_RF = 0;

    typedef enum logic [1:0] {
        HZ_IDLE       = 2'd0,
        HZ_LOAD_STALL = 2'd1,
        HZ_MEM_WAIT   = 2'd2,
        HZ_FLUSH      = 2'd3
    } hz_state_e;

    // The countdown only ever holds LOAD_LATENCY-1 down to 1.
    function automatic int cnt_width(input int latency);
        return (latency > 2) ? $clog2(latency) : 1;
    endfunction

endpackage

// File: rtl/lapido_fwd_select.sv
// lapido_fwd_select
//   Priority comparator choosing which downstream stage forwards to one
//   EX operand. Stage k (1-based) sits at slice k-1 of rd/we; the nearest
//   (lowest k) matching stage wins. Register 0 never forwards.
// Ports:
//   src  in   source register of the EX operand
//   rd   in   destination registers, stage k at slice k-1
//   we   in   write enables, stage k at bit k-1
//   sel  out  0 = register file, k = stage k
module lapido_fwd_select
    import lapido_hazard_ctrl_pkg::*;
#(
    parameter int STAGES = 2,
    parameter int ADDR_W = 5,
    parameter int SEL_W  = 2
) (
    input  logic [ADDR_W-1:0]        src,
    input  logic [STAGES*ADDR_W-1:0] rd,
    input  logic [STAGES-1:0]        we,
    output logic [SEL_W-1:0]         sel
);

    // Walk from the deepest stage toward stage 1 so the nearest match is
    // the last assignment and therefore wins.
    always_comb begin
        sel = SEL_W'(FWD_SEL_RF);
        if (src != '0) begin
            for (int k = STAGES; k >= 1; k--) begin
                if (we[k-1] && (rd[(k-1)*ADDR_W +: ADDR_W] == src)) begin
                    sel = SEL_W'(k);
                end
            end
        end
    end

endmodule

// File: rtl/lapido_hazard_ctrl.sv
// lapido_hazard_ctrl
//   Pipeline hazard controller: load-use stall with configurable latency,
//   memory-wait freeze, branch/jump flush, EX operand forwarding selects
//   and a saturating stall-cycle counter.
// Ports:
//   clk, rst                    clock, synchronous active-low reset
//   id_rs/id_rt/id_uses_*       sources of the instruction in IF/ID
//   ex_rs/ex_rt/ex_rd           registers of the instruction in ID/EX
//   ex_reg_write/ex_is_load     ID/EX control
//   fwd_rd/fwd_we               per-stage destinations and write enables
//   is_jump/branch_taken        control-flow redirects (ID / MEM)
//   mem_busy                    data memory not ready
//   stall_*/bubble_id_ex/flush  pipeline register controls
//   forward_a/forward_b         EX operand mux selects
//   stall_cycles                saturating count of stall_pc cycles
//   state                       FSM state for debug
module lapido_hazard_ctrl
    import lapido_hazard_ctrl_pkg::*;
#(
    parameter int GPR_ADDR_WIDTH = 5,
    parameter int FWD_STAGES     = 2,
    parameter int LOAD_LATENCY   = 1,
    parameter int FLUSH_DEPTH    = 3,
    parameter int PERF_WIDTH     = 32,
    localparam int SEL_W         = $clog2(FWD_STAGES + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [GPR_ADDR_WIDTH-1:0]        id_rs,
    input  logic [GPR_ADDR_WIDTH-1:0]        id_rt,
    input  logic                             id_uses_rs,
    input  logic                             id_uses_rt,
    input  logic [GPR_ADDR_WIDTH-1:0]        ex_rs,
    input  logic [GPR_ADDR_WIDTH-1:0]        ex_rt,
    input  logic [GPR_ADDR_WIDTH-1:0]        ex_rd,
    input  logic                             ex_reg_write,
    input  logic                             ex_is_load,
    input  logic [FWD_STAGES*GPR_ADDR_WIDTH-1:0] fwd_rd,
    input  logic [FWD_STAGES-1:0]            fwd_we,
    input  logic                             is_jump,
    input  logic                             branch_taken,
    input  logic                             mem_busy,
    output logic                             stall_pc,
    output logic                             stall_if_id,
    output logic                             stall_id_ex,
    output logic                             stall_ex_mem,
    output logic                             bubble_id_ex,
    output logic [FLUSH_DEPTH-1:0]           flush,
    output logic [SEL_W-1:0]                 forward_a,
    output logic [SEL_W-1:0]                 forward_b,
    output logic [PERF_WIDTH-1:0]            stall_cycles,
    output logic [1:0]                       state
);

    localparam int CNT_W = cnt_width(LOAD_LATENCY);

    generate
        if (FLUSH_DEPTH < 1 || LOAD_LATENCY < 1) begin : g_bad_params
            $error("lapido_hazard_ctrl: FLUSH_DEPTH and LOAD_LATENCY must be >= 1");
        end
    endgenerate

    hz_state_e        state_q, state_d;
    hz_state_e        saved_q, saved_d;
    hz_state_e        eff_state;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_use_hit;
    logic [SEL_W-1:0] sel_a, sel_b;

    lapido_fwd_select #(
        .STAGES (FWD_STAGES),
        .ADDR_W (GPR_ADDR_WIDTH),
        .SEL_W  (SEL_W)
    ) u_fwd_a (
        .src (ex_rs),
        .rd  (fwd_rd),
        .we  (fwd_we),
        .sel (sel_a)
    );

    lapido_fwd_select #(
        .STAGES (FWD_STAGES),
        .ADDR_W (GPR_ADDR_WIDTH),
        .SEL_W  (SEL_W)
    ) u_fwd_b (
        .src (ex_rt),
        .rd  (fwd_rd),
        .we  (fwd_we),
        .sel (sel_b)
    );

    assign forward_a = rst ? sel_a : '0;
    assign forward_b = rst ? sel_b : '0;
    assign state     = state_q;

    assign load_use_hit = ex_is_load && ex_reg_write && (ex_rd != '0) &&
                          ((id_uses_rs && (id_rs == ex_rd)) ||
                           (id_uses_rt && (id_rt == ex_rd)));

    // On the cycle mem_busy drops we already behave as the state we froze
    // in, so a pending load stall keeps holding IF/ID and a held branch
    // acts immediately; the state register catches up on the next edge.
    assign eff_state = (state_q == HZ_MEM_WAIT) ? saved_q : state_q;

    always_comb begin
        stall_pc     = 1'b0;
        stall_if_id  = 1'b0;
        stall_id_ex  = 1'b0;
        stall_ex_mem = 1'b0;
        bubble_id_ex = 1'b0;
        flush        = '0;
        state_d      = state_q;
        saved_d      = saved_q;
        cnt_d        = cnt_q;

        if (!rst) begin
            state_d = HZ_IDLE;
            saved_d = HZ_IDLE;
            cnt_d   = '0;
        end else if (mem_busy) begin
            stall_pc     = 1'b1;
            stall_if_id  = 1'b1;
            stall_id_ex  = 1'b1;
            stall_ex_mem = 1'b1;
            state_d      = HZ_MEM_WAIT;
            // Only capture on entry; staying in MEM_WAIT keeps the original.
            if (state_q != HZ_MEM_WAIT) saved_d = state_q;
        end else if (branch_taken) begin
            flush   = '1;
            state_d = HZ_FLUSH;
            saved_d = HZ_IDLE;
            cnt_d   = '0;
        end else begin
            saved_d = HZ_IDLE;
            case (eff_state)
                HZ_LOAD_STALL: begin
                    stall_pc     = 1'b1;
                    stall_if_id  = 1'b1;
                    bubble_id_ex = 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = HZ_IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = HZ_LOAD_STALL;
                        cnt_d   = cnt_q - CNT_W'(1);
                    end
                end
                HZ_FLUSH: begin
                    state_d = HZ_IDLE;
                end
                default: begin
                    state_d = HZ_IDLE;
                    if (load_use_hit) begin
                        stall_pc     = 1'b1;
                        stall_if_id  = 1'b1;
                        bubble_id_ex = 1'b1;
                        // First bubble is this cycle; the rest are counted down.
                        if (LOAD_LATENCY > 1) begin
                            state_d = HZ_LOAD_STALL;
                            cnt_d   = CNT_W'(LOAD_LATENCY - 1);
                        end
                    end else if (is_jump) begin
                        flush[0] = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= HZ_IDLE;
            saved_q      <= HZ_IDLE;
            cnt_q        <= '0;
            stall_cycles <= '0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            cnt_q   <= cnt_d;
            if (stall_pc && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + PERF_WIDTH'(1);
            end
        end
    end

endmodule
